// File: rtl/dvp_ddr3_wr_master.sv
// DVP pixel FIFO to Avalon-MM burst write master: captures one frame per arm
// into DDR3 starting at buffer_base and pulses img_end once the frame is accepted.
module dvp_ddr3_wr_master #(
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] buffer_base,
    input  logic [31:0] img_size,
    input  logic [31:0] start_status,
    input  logic [31:0] capture_en,
    output logic        img_end,
    output logic        busy,
    output logic        ovf,
    input  logic        pix_sof,
    input  logic        pix_valid,
    input  logic [31:0] pix_data,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    output logic [6:0]  avm_burstcount,
    input  logic        avm_waitrequest
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [6:0]  BURST_C = 7'(BURST_LEN);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_SOF, S_FILL, S_BURST, S_DONE} state_t;
    state_t r_state, w_next;

    logic [31:0]   r_cur_addr;
    logic [29:0]   r_words, r_rem, r_pushed;
    logic [6:0]    r_len, r_beat;
    logic          r_abort, r_ovf;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;

    logic       w_enable, w_arm, w_full, w_accept, w_last;
    logic       w_push_req, w_push, w_flush;
    logic [6:0] w_len;
    logic       w_unused;

    assign w_unused = &{1'b0, buffer_base[1:0], img_size[1:0], start_status[31:1], capture_en[31:1]};

    assign w_enable   = start_status[0] & capture_en[0];
    assign w_arm      = (r_state == S_IDLE) && w_enable;
    assign w_len      = (r_rem < 30'(BURST_LEN)) ? r_rem[6:0] : BURST_C;
    assign w_full     = (r_count == FULL_C);
    assign w_accept   = (r_state == S_BURST) && !avm_waitrequest;
    assign w_last     = w_accept && (r_beat == r_len - 7'd1);
    assign w_push_req = pix_valid &&
                        (((r_state == S_WAIT_SOF) && pix_sof && (r_rem != 30'd0)) ||
                         (((r_state == S_FILL) || (r_state == S_BURST)) && (r_pushed < r_words)));
    assign w_push     = w_push_req && !w_full;
    // FIFO is held empty in IDLE and emptied on every return to IDLE (abort or frame end).
    assign w_flush    = (r_state == S_IDLE) || (w_next == S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_enable) w_next = S_WAIT_SOF;
            S_WAIT_SOF: if (!w_enable)                  w_next = S_IDLE;
                        else if (r_rem == 30'd0)        w_next = S_DONE;
                        else if (pix_valid && pix_sof)  w_next = S_FILL;
            S_FILL:     if (!w_enable)                  w_next = S_IDLE;
                        else if (32'(r_count) >= 32'(w_len)) w_next = S_BURST;
            S_BURST:    if (w_last) begin
                            if (r_abort || !w_enable)       w_next = S_IDLE;
                            else if (r_rem == 30'(r_len))   w_next = S_DONE;
                            else                            w_next = S_FILL;
                        end
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = (r_state != S_IDLE);
        img_end        = (r_state == S_DONE);
        ovf            = r_ovf;
        avm_write      = 1'b0;
        avm_address    = 32'd0;
        avm_burstcount = 7'd0;
        avm_writedata  = 32'd0;
        avm_byteenable = 4'h0;
        if (r_state == S_BURST) begin
            avm_write      = 1'b1;
            avm_address    = r_cur_addr;
            avm_burstcount = r_len;
            avm_writedata  = r_mem[r_rd_ptr];
            avm_byteenable = 4'hF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr <= 32'd0;
            r_words    <= 30'd0;
            r_rem      <= 30'd0;
            r_pushed   <= 30'd0;
            r_len      <= 7'd0;
            r_beat     <= 7'd0;
            r_abort    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_arm) begin
                r_cur_addr <= {buffer_base[31:2], 2'b00};
                r_words    <= img_size[31:2];
                r_rem      <= img_size[31:2];
                r_pushed   <= 30'd0;
            end else if (w_push) begin
                r_pushed <= r_pushed + 30'd1;
            end
            if ((r_state == S_FILL) && (w_next == S_BURST)) begin
                r_len  <= w_len;
                r_beat <= 7'd0;
            end else if (w_accept) begin
                r_beat <= r_beat + 7'd1;
            end
            if (w_last) begin
                r_cur_addr <= r_cur_addr + {23'd0, r_len, 2'b00};
                r_rem      <= r_rem - 30'(r_len);
            end
            // An abort seen mid-burst is remembered until the burst has drained.
            if (r_state == S_IDLE)                      r_abort <= 1'b0;
            else if ((r_state == S_BURST) && !w_enable) r_abort <= 1'b1;
            if (w_arm)                     r_ovf <= 1'b0;
            else if (w_push_req && w_full) r_ovf <= 1'b1;
        end
    end

    // NOTE: the FIFO storage has no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= pix_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_accept) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_accept)      r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_accept) r_count <= r_count - (AW+1)'(1);
        end
    end

endmodule

// File: tb/tb_dvp_ddr3_wr_master.sv
// Directed bench for dvp_ddr3_wr_master: a cycle stepper drives pixels and a
// stalling Avalon slave, logs accepted beats, and each test checks the log.
module tb_dvp_ddr3_wr_master;

    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] buffer_base, img_size, start_status, capture_en;
    logic        img_end, busy, ovf;
    logic        pix_sof, pix_valid;
    logic [31:0] pix_data;
    logic [31:0] avm_address, avm_writedata;
    logic        avm_write, avm_waitrequest;
    logic [3:0]  avm_byteenable;
    logic [6:0]  avm_burstcount;

    always #10 clk = ~clk;

    dvp_ddr3_wr_master #(.BURST_LEN(BL), .FIFO_DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .buffer_base(buffer_base), .img_size(img_size),
        .start_status(start_status), .capture_en(capture_en),
        .img_end(img_end), .busy(busy), .ovf(ovf),
        .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_data(pix_data),
        .avm_address(avm_address), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit          hold_wait;
    int          stall_beat, stall_left, abort_beat, junk_left, pix_limit, pix_sent;
    int          nbeats, n_img_end;
    logic [31:0] pix_base;
    logic [31:0] q_addr[$], q_data[$];
    logic [6:0]  q_bc[$];
    logic [3:0]  q_be[$];
    bit          snap_valid;
    logic [31:0] snap_addr, snap_data;
    logic [6:0]  snap_bc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: act as slave and pixel source, then advance to 1 ns after the next edge.
    task automatic step();
        logic w;
        if (img_end) begin
            n_img_end++;
            capture_en = 32'd0;
        end
        w = hold_wait;
        if (avm_write && nbeats == stall_beat && stall_left > 0) begin
            w = 1'b1;
            if (!snap_valid) begin
                snap_valid = 1'b1;
                snap_addr  = avm_address;
                snap_data  = avm_writedata;
                snap_bc    = avm_burstcount;
            end else begin
                check("stall addr", avm_address, snap_addr);
                check("stall data", avm_writedata, snap_data);
                check("stall bc", 32'(avm_burstcount), 32'(snap_bc));
            end
            stall_left--;
        end
        avm_waitrequest = w;
        if (avm_write && !w) begin
            q_addr.push_back(avm_address);
            q_data.push_back(avm_writedata);
            q_bc.push_back(avm_burstcount);
            q_be.push_back(avm_byteenable);
            nbeats++;
        end
        if (abort_beat >= 0 && nbeats == abort_beat) capture_en = 32'd0;
        if (pix_sent < pix_limit) begin
            pix_valid = 1'b1;
            if (junk_left > 0) begin
                pix_sof  = 1'b0;
                pix_data = 32'hDEAD_0000 | 32'(junk_left);
                junk_left--;
            end else begin
                pix_sof  = (pix_sent == 0);
                pix_data = pix_base + 32'(pix_sent);
                pix_sent++;
            end
        end else begin
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [31:0] base, input logic [31:0] size);
        buffer_base = base;
        img_size    = size;
        capture_en  = 32'd1;
        pix_valid   = 1'b0;
        pix_sof     = 1'b0;
        nbeats      = 0;
        n_img_end   = 0;
        pix_sent    = 0;
        snap_valid  = 1'b0;
        q_addr.delete(); q_data.delete(); q_bc.delete(); q_be.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int max_cyc, input string tag);
        int c = 0;
        while (busy && c < max_cyc) begin
            step();
            c++;
        end
        check({tag, " idle in time"}, 32'(busy), 32'd0);
    endtask

    // Expected stream: word i at base + 64*(i/16), burst length min(16, words left), data d0+i.
    task automatic check_frame(input string tag, input logic [31:0] base, input int exp_beats,
                               input int total_words, input logic [31:0] d0);
        check({tag, " beats"}, 32'(nbeats), 32'(exp_beats));
        for (int i = 0; i < exp_beats && i < nbeats; i++) begin
            int b   = i / BL;
            int rem = total_words - b * BL;
            int bc  = (rem < BL) ? rem : BL;
            check($sformatf("%s data%0d", tag, i), q_data[i], d0 + 32'(i));
            check($sformatf("%s addr%0d", tag, i), q_addr[i], base + 32'(b * 64));
            check($sformatf("%s bc%0d", tag, i), 32'(q_bc[i]), 32'(bc));
            check($sformatf("%s be%0d", tag, i), 32'(q_be[i]), 32'hF);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        buffer_base = 32'd0; img_size = 32'd0; start_status = 32'd0; capture_en = 32'd0;
        pix_sof = 1'b0; pix_valid = 1'b0; pix_data = 32'd0; avm_waitrequest = 1'b0;
        hold_wait = 1'b0; stall_beat = -1; stall_left = 0; abort_beat = -1;
        junk_left = 0; pix_limit = 0; pix_sent = 0; pix_base = 32'd0;
        nbeats = 0; n_img_end = 0; snap_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst avm_write", 32'(avm_write), 32'd0);
        check("rst avm_address", avm_address, 32'd0);
        check("rst avm_burstcount", 32'(avm_burstcount), 32'd0);
        check("rst avm_byteenable", 32'(avm_byteenable), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst img_end", 32'(img_end), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        start_status = 32'd1;
        @(posedge clk);
        #1;
        check("idle busy", 32'(busy), 32'd0);

        // 256-byte frame, no stalls: four full bursts
        pix_base = 32'hA000_0000; pix_limit = 64;
        arm(32'h3000_0000, 32'd256);
        run_until_idle(400, "t1");
        check_frame("t1", 32'h3000_0000, 64, 64, pix_base);
        check("t1 img_end count", 32'(n_img_end), 32'd1);

        // 72-byte frame, unaligned size bits ignored elsewhere: bursts of 16 and 2
        pix_base = 32'hB000_0000; pix_limit = 18;
        arm(32'h1000_0102, 32'd75);
        run_until_idle(400, "t2");
        check_frame("t2", 32'h1000_0100, 18, 18, pix_base);
        check("t2 img_end count", 32'(n_img_end), 32'd1);

        // three-cycle waitrequest on beat 5
        pix_base = 32'hC000_0000; pix_limit = 32; stall_beat = 5; stall_left = 3;
        arm(32'h2000_0000, 32'd128);
        run_until_idle(400, "t3");
        check_frame("t3", 32'h2000_0000, 32, 32, pix_base);
        check("t3 stall consumed", 32'(stall_left), 32'd0);
        check("t3 img_end count", 32'(n_img_end), 32'd1);
        stall_beat = -1;

        // capture_en drops after beat 20: burst 2 drains, no img_end, FIFO emptied
        pix_base = 32'hD000_0000; pix_limit = 64; abort_beat = 20;
        arm(32'h4000_0000, 32'd256);
        run_until_idle(400, "t5");
        check_frame("t5", 32'h4000_0000, 32, 64, pix_base);
        check("t5 img_end count", 32'(n_img_end), 32'd0);
        check("t5 fifo empty", 32'(dut.r_count), 32'd0);
        abort_beat = -1;

        // 100 junk words before sof are discarded
        pix_base = 32'hE000_0000; pix_limit = 16; junk_left = 100;
        arm(32'h5000_0000, 32'd64);
        run_until_idle(400, "t4");
        check_frame("t4", 32'h5000_0000, 16, 16, pix_base);
        check("t4 img_end count", 32'(n_img_end), 32'd1);

        // slave stalls until the FIFO is full, then 3 extra pixels overflow
        pix_base = 32'hF000_0000; pix_limit = 64; hold_wait = 1'b1;
        arm(32'h6000_0000, 32'd1024);
        repeat (70) step();
        check("t6 ovf before full", 32'(ovf), 32'd0);
        check("t6 fifo full", 32'(dut.r_count), 32'd64);
        check("t6 write pending", 32'(avm_write), 32'd1);
        pix_limit = 67;
        repeat (5) step();
        check("t6 ovf set", 32'(ovf), 32'd1);
        capture_en = 32'd0;
        hold_wait  = 1'b0;
        run_until_idle(100, "t6");
        check_frame("t6", 32'h6000_0000, 16, 256, pix_base);
        check("t6 ovf sticky", 32'(ovf), 32'd1);
        check("t6 img_end count", 32'(n_img_end), 32'd0);

        // zero-size frame: img_end two cycles after arm, ovf cleared on arm
        pix_limit = 0;
        arm(32'h7000_0000, 32'd0);
        check("z ovf cleared", 32'(ovf), 32'd0);
        check("z img_end early", 32'(img_end), 32'd0);
        check("z busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("z img_end pulse", 32'(img_end), 32'd1);
        capture_en = 32'd0;
        @(posedge clk);
        #1;
        check("z img_end one cycle", 32'(img_end), 32'd0);
        check("z back idle", 32'(busy), 32'd0);

        // asynchronous reset in the middle of a burst
        pix_base = 32'h1234_0000; pix_limit = 64;
        arm(32'h8000_0000, 32'd256);
        for (int c = 0; c < 100 && !avm_write; c++) step();
        check("mid reach burst", 32'(avm_write), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("mid rst avm_write", 32'(avm_write), 32'd0);
        check("mid rst avm_address", avm_address, 32'd0);
        check("mid rst burstcount", 32'(avm_burstcount), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        capture_en = 32'd0;
        pix_valid  = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post rst idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
